bin_to_bcd_seq: RTL
===================

// Module: bin_to_bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3). Converts an unsigned
//   BIN_W-bit value into DIGITS packed BCD digits for the BCD-to-seven-segment
//   decoder stage downstream. Each 4-bit digit slice feeds one decoder's in[3:0].
//   One bit is processed per clock, with a start/busy/done handshake.
// PARAMETERS
//   BIN_W   14  width of binary input (legal: 4..32)
//   DIGITS   4  number of BCD digits produced (legal: 1..10)
// PORTS
//   clk       in   1          single clock, rising edge
//   rst       in   1          asynchronous, active-high reset
//   start     in   1          request conversion of bin (sampled on clk rise)
//   bin       in   BIN_W      unsigned binary value, captured when start accepted
//   busy      out  1          conversion in progress
//   done      out  1          one-cycle pulse: bcd/overflow hold new result
//   bcd       out  4*DIGITS   packed result; digit k in bcd[4k+3:4k], k=0 is units
//   overflow  out  1          result >= 10**DIGITS; bcd holds value mod 10**DIGITS
// BEHAVIOUR
//   Reset (async): state=IDLE; busy=0, done=0, bcd=0, overflow=0; work regs=0.
//   States: IDLE, CONV, DONE.
//   - IDLE: start=1 -> CONV; capture bin into shift reg, clear BCD work reg and
//     sticky ovf flag, bit counter=BIN_W-1. start=0 -> stay.
//   - CONV: each cycle: for every work digit >=5 add 3 (all digits in parallel),
//     then shift {work_bcd, bin_shift} left 1; bit shifted out of the top digit
//     ORs into sticky ovf. Counter decrements; after bit 0 processed -> DONE and
//     bcd<=work_bcd, overflow<=ovf on the same edge. start ignored in CONV.
//   - DONE: done=1 for exactly this cycle. start=1 here is accepted exactly as
//     in IDLE (-> CONV, back-to-back); else -> IDLE.
//   busy=1 exactly while state==CONV; done=1 exactly while state==DONE; both
//     registered outputs, never high together.
//   Latency: start sampled at edge E -> busy high from E to E+BIN_W; done high
//     in the cycle after edge E+BIN_W (BIN_W cycles after start). Throughput:
//     one result per BIN_W+1 cycles with back-to-back start.
//   bin is only read at the accepting edge; changes during CONV have no effect.
//   bcd/overflow hold the last completed result until the next DONE; they are
//     not cleared by start. Every digit of bcd is always in 0..9.
//   Reset asserted mid-conversion aborts immediately: no done, outputs to reset
//     values; first start after release behaves as from IDLE.
//   overflow is exact: set iff bin >= 10**DIGITS (sticky over all shifts).
// TESTING
//   bin=0, start 1 cycle -> done after 14 cycles, bcd=16'h0000, overflow=0.
//   bin=9999 -> bcd=16'h9999, overflow=0; bin=10000 -> bcd=16'h0000, overflow=1;
//     bin=16383 -> bcd=16'h6383, overflow=1.
//   bin=1234, start held high continuously -> done pulses every 15 cycles,
//     bcd=16'h1234 each time; busy never drops between runs except in DONE.
//   start with bin=42, change bin to 777 and pulse start during busy ->
//     result bcd=16'h0042, only one done pulse.
//   Assert rst at cycle 7 of a conversion of 5678 -> busy/done/bcd=0 at once;
//     next start with bin=5678 -> bcd=16'h5678 after 14 cycles.
//   200 random bin in 0..16383 vs behavioural model (bin%10000 digits,
//     bin>=10000) -> all match; each 4-bit slice fed to the decoder is <=9.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter: one input bit per clock,
// start/busy/done handshake, exact overflow flag for values >= 10**DIGITS.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int unsigned BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   corrected;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      work_q     <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      work_q     <= work_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    work_d     = work_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    corrected = work_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) begin
        corrected[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CONV;
          shift_d = bin;
          work_d  = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W - 1);
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        // A bit leaving the top digit means the true value needs more digits.
        work_d  = {corrected[BCD_W-2:0], shift_q[BIN_W-1]};
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        ovf_d   = ovf_q | corrected[BCD_W-1];
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          bcd_d      = work_d;
          overflow_d = ovf_d;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule
